// File: rtl/led_pattern_ctrl_pkg.sv
// Shared constants for the LED pattern controller.
// Mode codes, speed levels and ping-pong direction.
package lchika_pkg;

  localparam logic [1:0] MODE_ROTL  = 2'd0;
  localparam logic [1:0] MODE_ROTR  = 2'd1;
  localparam logic [1:0] MODE_PING  = 2'd2;
  localparam logic [1:0] MODE_COUNT = 2'd3;

  localparam int NSPEED   = 4;
  localparam int SPW      = $clog2(NSPEED);
  localparam int DEF_NLED = 4;

  typedef enum logic {
    DIR_L = 1'b0,
    DIR_R = 1'b1
  } dir_t;

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Button pulses in, LED bank and status out.
// master = button source / observer, slave = controller.
interface led_pattern_ctrl_if
  import lchika_pkg::*;
#(
  parameter int NLED = DEF_NLED
) ();

  logic            BTN_MODE;
  logic            BTN_SPEED;
  logic            BTN_RUN;
  logic [NLED-1:0] LED;
  logic [1:0]      MODE;
  logic [SPW-1:0]  SPEED;
  logic            RUNNING;

  modport master (
    output BTN_MODE, BTN_SPEED, BTN_RUN,
    input  LED, MODE, SPEED, RUNNING
  );

  modport slave (
    input  BTN_MODE, BTN_SPEED, BTN_RUN,
    output LED, MODE, SPEED, RUNNING
  );

endinterface

// File: rtl/led_pattern_ctrl_step_tick_gen.sv
// Step prescaler: period BASE_DIV >> shift, holds when
// disabled, sync clear; tick on the last count of a period.
module step_tick_gen
  import lchika_pkg::*;
#(
  parameter int BASE_DIV = 12500000
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           en,
  input  logic           clr,
  input  logic [SPW-1:0] shift,
  output logic           tick
);

  localparam int CW = $clog2(BASE_DIV);

  logic [CW-1:0] cnt;
  logic [31:0]   lim;
  logic          hit;

  // limit kept 32 bits wide: BASE_DIV itself may not fit CW bits
  assign lim  = (32'(BASE_DIV) >> shift) - 32'd1;
  assign hit  = (32'(cnt) == lim);
  assign tick = en & hit;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= hit ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Running-light LED controller: mode/speed/run pulses
// select pattern, step rate and pause state.
module led_pattern_ctrl
  import lchika_pkg::*;
#(
  parameter int NLED     = DEF_NLED,
  parameter int BASE_DIV = 12500000
) (
  input logic               CLK,
  input logic               RST,
  led_pattern_ctrl_if.slave bus
);

  localparam logic [NLED-1:0] ONE = NLED'(1);

  logic [NLED-1:0] led, led_n;
  logic [1:0]      mode, mode_n;
  logic [SPW-1:0]  speed, speed_n;
  logic            running, running_n;
  dir_t            dir, dir_n;
  logic            tick;
  logic            ev;

  function automatic logic [NLED-1:0] init_pat(
    input logic [1:0] m
  );
    logic [NLED-1:0] p;
    p = ONE;
    if (m == MODE_ROTR) p = ONE << (NLED - 1);
    if (m == MODE_COUNT) p = '0;
    return p;
  endfunction

  assign ev = bus.BTN_MODE | bus.BTN_SPEED;

  step_tick_gen #(
    .BASE_DIV(BASE_DIV)
  ) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .en   (running),
    .clr  (ev),
    .shift(speed),
    .tick (tick)
  );

  always_comb begin
    led_n     = led;
    mode_n    = mode;
    speed_n   = speed;
    running_n = running;
    dir_n     = dir;
    if (bus.BTN_RUN) running_n = ~running;
    if (bus.BTN_SPEED) speed_n = speed + SPW'(1);
    if (bus.BTN_MODE) begin
      mode_n = mode + 2'd1;
      led_n  = init_pat(mode_n);
      dir_n  = DIR_L;
    end else if (tick && !ev) begin
      unique case (mode)
        MODE_ROTL:
          led_n = {led[NLED-2:0], led[NLED-1]};
        MODE_ROTR:
          led_n = {led[0], led[NLED-1:1]};
        MODE_PING: begin
          if (dir == DIR_L) begin
            if (led[NLED-1]) begin
              led_n = ONE << (NLED - 2);
              dir_n = DIR_R;
            end else begin
              led_n = led << 1;
            end
          end else begin
            if (led[0]) begin
              led_n = ONE << 1;
              dir_n = DIR_L;
            end else begin
              led_n = led >> 1;
            end
          end
        end
        MODE_COUNT:
          led_n = led + ONE;
        default:
          led_n = led;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      led     <= ONE;
      mode    <= MODE_ROTL;
      speed   <= '0;
      running <= 1'b1;
      dir     <= DIR_L;
    end else begin
      led     <= led_n;
      mode    <= mode_n;
      speed   <= speed_n;
      running <= running_n;
      dir     <= dir_n;
    end
  end

  assign bus.LED     = led;
  assign bus.MODE    = mode;
  assign bus.SPEED   = speed;
  assign bus.RUNNING = running;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl, NLED=4, BASE_DIV=8.
// Inputs change 1 time unit after each rising edge.
module tb_led_pattern_ctrl;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  led_pattern_ctrl_if #(.NLED(4)) bus ();

  led_pattern_ctrl #(
    .NLED    (4),
    .BASE_DIV(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic status(
    input string      tag,
    input logic [1:0] m,
    input logic [1:0] s,
    input logic       r
  );
    chk({tag, "_mode"}, 32'(bus.MODE), 32'(m));
    chk({tag, "_speed"}, 32'(bus.SPEED), 32'(s));
    chk({tag, "_run"}, 32'(bus.RUNNING), 32'(r));
  endtask

  initial begin
    logic [3:0] ping [7];
    ping = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
             4'b0010, 4'b0001, 4'b0010};
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus.BTN_MODE  = 1'b0;
    bus.BTN_SPEED = 1'b0;
    bus.BTN_RUN   = 1'b0;
    step(2);
    chk("rst_led", 32'(bus.LED), 32'h1);
    status("rst", 2'd0, 2'd0, 1'b1);
    RST = 1'b0;

    // rotate left, step every 8 edges
    step(7);
    chk("rotl_e7", 32'(bus.LED), 32'h1);
    step(1);
    chk("rotl_e8", 32'(bus.LED), 32'h2);
    step(8);
    chk("rotl_e16", 32'(bus.LED), 32'h4);
    step(8);
    chk("rotl_e24", 32'(bus.LED), 32'h8);
    step(8);
    chk("rotl_e32", 32'(bus.LED), 32'h1);
    status("rotl", 2'd0, 2'd0, 1'b1);

    // speed 1: step every 4
    bus.BTN_SPEED = 1'b1;
    step(1);
    bus.BTN_SPEED = 1'b0;
    chk("spd1", 32'(bus.SPEED), 32'd1);
    step(3);
    chk("spd1_e3", 32'(bus.LED), 32'h1);
    step(1);
    chk("spd1_e4", 32'(bus.LED), 32'h2);
    step(4);
    chk("spd1_e8", 32'(bus.LED), 32'h4);

    // three back-to-back speed events wrap to 0
    bus.BTN_SPEED = 1'b1;
    step(3);
    bus.BTN_SPEED = 1'b0;
    chk("spd_wrap", 32'(bus.SPEED), 32'd0);
    step(7);
    chk("spd0_e7", 32'(bus.LED), 32'h4);
    step(1);
    chk("spd0_e8", 32'(bus.LED), 32'h8);

    // mode 1: rotate right
    bus.BTN_MODE = 1'b1;
    step(1);
    bus.BTN_MODE = 1'b0;
    chk("m1_init", 32'(bus.LED), 32'h8);
    chk("m1_mode", 32'(bus.MODE), 32'd1);
    step(7);
    chk("m1_e7", 32'(bus.LED), 32'h8);
    step(1);
    chk("m1_e8", 32'(bus.LED), 32'h4);

    // mode 2: ping-pong
    bus.BTN_MODE = 1'b1;
    step(1);
    bus.BTN_MODE = 1'b0;
    chk("m2_init", 32'(bus.LED), 32'h1);
    for (int i = 0; i < 7; i++) begin
      step(8);
      chk($sformatf("m2_s%0d", i), 32'(bus.LED), 32'(ping[i]));
    end

    // mode 3: binary count, wraps at 16
    bus.BTN_MODE = 1'b1;
    step(1);
    bus.BTN_MODE = 1'b0;
    chk("m3_init", 32'(bus.LED), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      step(8);
      chk($sformatf("m3_s%0d", i), 32'(bus.LED), 32'(i % 16));
    end

    // pause with count at 3, resume finishes the period
    step(3);
    bus.BTN_RUN = 1'b1;
    step(1);
    bus.BTN_RUN = 1'b0;
    chk("pause_run", 32'(bus.RUNNING), 32'd0);
    step(100);
    chk("pause_led", 32'(bus.LED), 32'h0);
    chk("pause_run2", 32'(bus.RUNNING), 32'd0);
    bus.BTN_RUN = 1'b1;
    step(1);
    bus.BTN_RUN = 1'b0;
    chk("resume_run", 32'(bus.RUNNING), 32'd1);
    step(3);
    chk("resume_e4", 32'(bus.LED), 32'h0);
    step(1);
    chk("resume_e5", 32'(bus.LED), 32'h1);

    // mode+speed on a tick edge: step dropped, init loaded
    step(7);
    bus.BTN_MODE  = 1'b1;
    bus.BTN_SPEED = 1'b1;
    step(1);
    bus.BTN_MODE  = 1'b0;
    bus.BTN_SPEED = 1'b0;
    chk("both_led", 32'(bus.LED), 32'h1);
    status("both", 2'd0, 2'd1, 1'b1);
    step(3);
    chk("both_e3", 32'(bus.LED), 32'h1);
    step(1);
    chk("both_e4", 32'(bus.LED), 32'h2);

    // speed alone on a tick edge suppresses the step
    step(3);
    bus.BTN_SPEED = 1'b1;
    step(1);
    bus.BTN_SPEED = 1'b0;
    chk("spdtick_led", 32'(bus.LED), 32'h2);
    chk("spdtick_spd", 32'(bus.SPEED), 32'd2);
    step(1);
    chk("spd2_e1", 32'(bus.LED), 32'h2);
    step(1);
    chk("spd2_e2", 32'(bus.LED), 32'h4);

    // mode 2, speed 3, paused, then reset
    bus.BTN_MODE  = 1'b1;
    bus.BTN_SPEED = 1'b1;
    step(1);
    bus.BTN_SPEED = 1'b0;
    step(1);
    bus.BTN_MODE = 1'b0;
    chk("pre_init", 32'(bus.LED), 32'h1);
    step(2);
    chk("pre_ping", 32'(bus.LED), 32'h4);
    bus.BTN_RUN = 1'b1;
    step(1);
    bus.BTN_RUN = 1'b0;
    chk("pre_led", 32'(bus.LED), 32'h8);
    status("pre", 2'd2, 2'd3, 1'b0);
    step(3);
    chk("pre_hold", 32'(bus.LED), 32'h8);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    chk("mid_rst_led", 32'(bus.LED), 32'h1);
    status("mid_rst", 2'd0, 2'd0, 1'b1);
    step(7);
    chk("post_e7", 32'(bus.LED), 32'h1);
    step(1);
    chk("post_e8", 32'(bus.LED), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
